// File: rtl/irq_ctrl_pkg.sv
// irq_pkg: shared definitions for the interrupt controller.
//   reg_idx_e : word register index decoded from the bus address
//   DEF_NSRC  : default number of interrupt sources
package irq_pkg;

   localparam int unsigned DEF_NSRC = 8;

   typedef enum logic [2:0] {
      REG_PEND     = 3'd0,
      REG_EN       = 3'd1,
      REG_EDGE     = 3'd2,
      REG_INSV     = 3'd3,
      REG_CLAIM    = 3'd4,
      REG_COMPLETE = 3'd5
   } reg_idx_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: register access bus of the interrupt controller.
//   sel   : access strobe, one cycle per access
//   we    : write enable, qualified by sel
//   addr  : word register index
//   wdata : write data
//   rdata : registered read data, valid the cycle after a read strobe
interface irq_ctrl_if;

   logic        sel;
   logic        we;
   logic [2:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output sel, we, addr, wdata, input rdata);
   modport slave  (input sel, we, addr, wdata, output rdata);

endinterface

// File: rtl/irq_ctrl_sync2.sv
// sync2: parameterized-width two-flop synchronizer, synchronous reset to 0.
// Only compiled when IRQ_CTRL_SYNC_EN is defined.
//   clk, rst : clock and synchronous active-high reset
//   d        : asynchronous input vector
//   q        : synchronized output vector (two cycles of latency)
`ifdef IRQ_CTRL_SYNC_EN
module sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule
`endif

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller with per-source edge/level mode,
// enable mask, claim/complete in-service tracking and a registered irq.
//   clk, rst : clock and synchronous active-high reset
//   src      : raw interrupt request lines (NSRC wide)
//   bus      : register access interface (slave side)
//   irq      : registered interrupt request
// Registers: 0 PEND (R/W1C), 1 EN, 2 EDGE, 3 INSV (R), 4 CLAIM (R),
// 5 COMPLETE (W).
// Macro IRQ_CTRL_SYNC_EN: route src through a 2-flop synchronizer.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int unsigned NSRC = DEF_NSRC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src,
   irq_ctrl_if.slave       bus,
   output logic            irq
);

   logic [NSRC-1:0] src_s;
   logic [NSRC-1:0] src_prev_q, src_prev_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] en_q, en_d;
   logic [NSRC-1:0] edge_q, edge_d;
   logic [NSRC-1:0] insv_q, insv_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            irq_q, irq_d;

   logic            rd_acc, wr_acc;
   logic [NSRC-1:0] cand, claim_oh, w1c_mask, done_oh;
   logic [31:0]     claim_val;

`ifdef IRQ_CTRL_SYNC_EN
   sync2 #(.WIDTH(NSRC)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (src),
      .q   (src_s)
   );
`else
   assign src_s = src;
`endif

   always_comb begin
      rd_acc = bus.sel && !bus.we;
      wr_acc = bus.sel && bus.we;

      cand = pend_q & en_q & ~insv_q;

      // Scan downward so the lowest set index wins.
      claim_val = '0;
      claim_oh  = '0;
      for (int unsigned i = NSRC; i > 0; i--) begin
         if (cand[i-1]) begin
            claim_val   = 32'(i);
            claim_oh    = '0;
            claim_oh[i-1] = 1'b1;
         end
      end
      if (!(rd_acc && bus.addr == REG_CLAIM)) begin
         claim_oh = '0;
      end

      w1c_mask = (wr_acc && bus.addr == REG_PEND) ? bus.wdata[NSRC-1:0] : '0;

      done_oh = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (wr_acc && bus.addr == REG_COMPLETE && bus.wdata == 32'(i + 1)) begin
            done_oh[i] = 1'b1;
         end
      end

      src_prev_d = src_s;

      // A fresh edge beats a same-cycle clear so the event is not lost.
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (edge_q[i]) begin
            pend_d[i] = (pend_q[i] && !w1c_mask[i] && !claim_oh[i])
                        || (src_s[i] && !src_prev_q[i]);
         end else begin
            pend_d[i] = src_s[i];
         end
      end

      en_d   = (wr_acc && bus.addr == REG_EN)   ? bus.wdata[NSRC-1:0] : en_q;
      edge_d = (wr_acc && bus.addr == REG_EDGE) ? bus.wdata[NSRC-1:0] : edge_q;
      insv_d = (insv_q | claim_oh) & ~done_oh;
      irq_d  = |cand;

      rdata_d = rdata_q;
      if (rd_acc) begin
         case (bus.addr)
            REG_PEND:  rdata_d = 32'(pend_q);
            REG_EN:    rdata_d = 32'(en_q);
            REG_EDGE:  rdata_d = 32'(edge_q);
            REG_INSV:  rdata_d = 32'(insv_q);
            REG_CLAIM: rdata_d = claim_val;
            default:   rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_prev_q <= '0;
         pend_q     <= '0;
         en_q       <= '0;
         edge_q     <= '0;
         insv_q     <= '0;
         rdata_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         src_prev_q <= src_prev_d;
         pend_q     <= pend_d;
         en_q       <= en_d;
         edge_q     <= edge_d;
         insv_q     <= insv_d;
         rdata_q    <= rdata_d;
         irq_q      <= irq_d;
      end
   end

   assign bus.rdata = rdata_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: randomized and directed stimulus for irq_ctrl with a
// behavioural reference model and an expectation queue.
module tb_irq_ctrl;
   import irq_pkg::*;

   localparam int unsigned NSRC = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [NSRC-1:0] src;
   logic            irq;

   irq_ctrl_if bus ();

   irq_ctrl #(.NSRC(NSRC)) dut (
      .clk (clk),
      .rst (rst),
      .src (src),
      .bus (bus),
      .irq (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          chk_rd;
      logic [31:0] rdata;
      logic        irq;
      string       tag;
   } exp_t;

   exp_t expq[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Reference model state, one entry per source.
   bit m_pend [NSRC];
   bit m_en   [NSRC];
   bit m_edge [NSRC];
   bit m_insv [NSRC];
   bit m_prev [NSRC];
   bit m_s1   [NSRC];
   bit m_s2   [NSRC];

   logic [NSRC-1:0] cur_src = '0;

   function automatic logic [31:0] pack(input bit v [NSRC]);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < NSRC; i++) r[i] = v[i];
      return r;
   endfunction

   task automatic step(input bit r, input bit sl, input bit w, input logic [2:0] a,
                       input logic [31:0] wd, input logic [NSRC-1:0] s, input string tag);
      exp_t e;
      bit   ss [NSRC];
      int   first;
      int   claimed;
      bit   rise, clr;
      rst = r; bus.sel = sl; bus.we = w; bus.addr = a; bus.wdata = wd; src = s;
      e.tag    = tag;
      e.chk_rd = r || (sl && !w);
      e.rdata  = '0;
      e.irq    = 1'b0;
      if (r) begin
         for (int i = 0; i < NSRC; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_insv[i] = 0;
            m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
         end
      end else begin
         for (int i = 0; i < NSRC; i++) begin
`ifdef IRQ_CTRL_SYNC_EN
            ss[i] = m_s2[i];
`else
            ss[i] = s[i];
`endif
         end
         first = -1;
         for (int i = NSRC - 1; i >= 0; i--)
            if (m_pend[i] && m_en[i] && !m_insv[i]) first = i;
         e.irq = (first >= 0);
         if (sl && !w) begin
            case (a)
               3'd0:    e.rdata = pack(m_pend);
               3'd1:    e.rdata = pack(m_en);
               3'd2:    e.rdata = pack(m_edge);
               3'd3:    e.rdata = pack(m_insv);
               3'd4:    e.rdata = 32'(first + 1);
               default: e.rdata = '0;
            endcase
         end
         claimed = (sl && !w && a == 3'd4) ? first : -1;
         for (int i = 0; i < NSRC; i++) begin
            if (m_edge[i]) begin
               rise = ss[i] && !m_prev[i];
               clr  = (sl && w && a == 3'd0 && wd[i]) || (claimed == i);
               if (rise)     m_pend[i] = 1;
               else if (clr) m_pend[i] = 0;
            end else begin
               m_pend[i] = ss[i];
            end
            if (claimed == i) m_insv[i] = 1;
            if (sl && w && a == 3'd5 && wd == 32'(i + 1)) m_insv[i] = 0;
            if (sl && w && a == 3'd1) m_en[i]   = wd[i];
            if (sl && w && a == 3'd2) m_edge[i] = wd[i];
            m_prev[i] = ss[i];
            m_s2[i]   = m_s1[i];
            m_s1[i]   = s[i];
         end
      end
      expq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 3'd0, '0, cur_src, "idle");
   endtask

   task automatic do_rst(input int n);
      for (int k = 0; k < n; k++) step(1, 0, 0, 3'd0, '0, cur_src, "reset");
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      step(0, 1, 1, a, d, cur_src, "write");
   endtask

   task automatic rd(input logic [2:0] a, input string tag);
      step(0, 1, 0, a, '0, cur_src, tag);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if (irq !== e.irq) begin
               n_bad++;
               $display("FAIL irq after %s: got %b expected %b at %0t", e.tag, irq, e.irq, $time);
            end
            if (e.chk_rd) begin
               n_cmp++;
               if (bus.rdata !== e.rdata) begin
                  n_bad++;
                  $display("FAIL rdata after %s: got %h expected %h at %0t",
                           e.tag, bus.rdata, e.rdata, $time);
               end
            end
         end
      end
   end

   initial begin : stimulus
      logic [2:0]  a;
      logic [31:0] d;
      cur_src = '0;
      do_rst(2);

      // Edge source 0: pulse, claim, complete.
      wr(3'd1, 32'h01); wr(3'd2, 32'h01);
      cur_src = 8'h01; idle(1); cur_src = 8'h00; idle(4);
      rd(3'd0, "pend"); rd(3'd4, "claim"); rd(3'd0, "pend"); rd(3'd3, "insv");
      idle(2); wr(3'd5, 32'd1); idle(2);

      // Level sources 2 and 3.
      do_rst(1);
      wr(3'd1, 32'h0C); cur_src = 8'h0C; idle(3);
      rd(3'd4, "claim_a"); rd(3'd3, "insv"); rd(3'd4, "claim_b"); rd(3'd4, "claim_c");
      cur_src = 8'h04; wr(3'd5, 32'd3); idle(3); rd(3'd4, "claim_d"); idle(2);

      // Edge arrives in the same cycle as W1C.
      do_rst(1); cur_src = '0;
      wr(3'd2, 32'h02); wr(3'd1, 32'h02);
      cur_src = 8'h02; idle(3); cur_src = 8'h00; idle(3);
      cur_src = 8'h02; idle(2); cur_src = 8'h00; idle(1);
      rd(3'd0, "pend_pre");
      cur_src = 8'h02; wr(3'd0, 32'h02); rd(3'd0, "pend_w1c"); idle(2);

      // Pending but disabled, then enabled.
      do_rst(1); cur_src = '0;
      wr(3'd2, 32'h10); cur_src = 8'h10; idle(4);
      rd(3'd0, "pend"); rd(3'd4, "claim_dis"); wr(3'd1, 32'h10); idle(3);

      // Reset in the middle of service; out-of-range complete.
      do_rst(1); cur_src = '0;
      wr(3'd1, 32'h01); wr(3'd2, 32'h01);
      cur_src = 8'h01; idle(4); cur_src = 8'h00;
      rd(3'd4, "claim"); rd(3'd3, "insv");
      step(1, 1, 0, 3'd4, '0, cur_src, "rst_read");
      for (int k = 0; k < 6; k++) rd(3'(k), "post_rst");
      wr(3'd1, 32'h01); wr(3'd2, 32'h01);
      cur_src = 8'h01; idle(4); cur_src = 8'h00;
      rd(3'd4, "claim"); wr(3'd5, 32'd9); rd(3'd3, "insv_keep");
      wr(3'd5, 32'd1); rd(3'd3, "insv_clr"); idle(2);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         for (int b = 0; b < NSRC; b++)
            if ($urandom_range(0, 9) == 0) cur_src[b] = ~cur_src[b];
         if ($urandom_range(0, 299) == 0) begin
            do_rst(1);
         end else if ($urandom_range(0, 1) == 0) begin
            a = 3'($urandom_range(0, 7));
            d = (a == 3'd5) ? 32'($urandom_range(0, NSRC + 2)) : ($urandom & 32'h0000_0FFF);
            step(0, 1, 1'($urandom_range(0, 1)), a, d, cur_src, "rand");
         end else begin
            idle(1);
         end
      end
      idle(2);

      @(negedge clk);
      #1;
      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d entries expected 0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 8, SHALL set the number of interrupt sources (1..31).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 src  input  NSRC  raw interrupt request lines from peripherals.
REQ-005 sel  input  1  register access strobe, one cycle per access.
REQ-006 we  input  1  write enable, qualified by sel.
REQ-007 addr  input  3  word register index.
REQ-008 wdata  input  32  write data.
REQ-009 rdata  output  32  read data, registered, valid the cycle after sel&&!we.
REQ-010 irq  output  1  registered interrupt request to the core's exception unit.

Function
REQ-011 Registers by addr SHALL be: 0 PEND (R, W1C), 1 EN (RW), 2 EDGE (RW, 1=edge, 0=level), 3 INSV (R), 4 CLAIM (R), 5 COMPLETE (W); others read 0 and ignore writes; bits at or above NSRC read 0.
REQ-012 src_s SHALL be the synchronized src (REQ-025); src_prev SHALL register src_s every cycle.
REQ-013 Edge source i: PEND[i] SHALL set when src_s[i]&&!src_prev[i]; clear only by W1C or claim.
REQ-014 Level source i: PEND[i] SHALL equal src_s[i] registered each cycle; W1C and claim SHALL not affect it.
REQ-015 irq SHALL register |(PEND & EN & ~INSV) each cycle.
REQ-016 Reading CLAIM SHALL return lowest index i with PEND&EN&~INSV set, encoded i+1, or 0 if none.
REQ-017 A nonzero claim SHALL, in the same cycle, set INSV[i] and clear PEND[i] for an edge source.
REQ-018 A zero claim SHALL have no side effects.
REQ-019 Writing COMPLETE with wdata=i+1 (i<NSRC) SHALL clear INSV[i]; other values SHALL be ignored.
REQ-020 Same-cycle edge detect and clear (W1C or claim) on one source SHALL leave PEND set.
REQ-021 Writing EDGE SHALL not alter PEND; the next cycle's evaluation SHALL use the new mode.
REQ-022 Latency without sync: src rising before edge E SHALL set PEND at E and irq at E+1.

Reset
REQ-023 While rst is high, PEND, EN, EDGE, INSV, src_prev, synchronizer flops, rdata and irq SHALL be 0.
REQ-024 Any access concurrent with rst SHALL be discarded; an in-flight read SHALL return 0.

Configuration
REQ-025 Macro IRQ_CTRL_SYNC_EN defined: src SHALL pass a 2-flop synchronizer, adding 2 cycles (irq at E+3). Undefined: src_s = src combinationally and REQ-022 holds.

Structure
REQ-026 Package irq_pkg SHALL hold the register index enum (PEND, EN, EDGE, INSV, CLAIM, COMPLETE) and the default NSRC constant.
REQ-027 Sub-module sync2 (parameterized-width 2-flop synchronizer, reset to 0) SHALL be instantiated only under IRQ_CTRL_SYNC_EN.

Verification
REQ-028 EN=0x01, EDGE=0x01, pulse src[0] one cycle -> PEND=0x01, irq=1 at E+1 (E+3 with sync); CLAIM reads 1; PEND=0, INSV=0x01, irq=0 next cycle.
REQ-029 EN=0x0C, level src[2] and src[3] high -> CLAIM=3, INSV=0x04; second CLAIM=4; third CLAIM=0; COMPLETE=3 with src[2] still high -> irq reasserts.
REQ-030 Edge src[1] rises in the cycle of W1C PEND=0x02 -> PEND[1] stays 1.
REQ-031 PEND=0x10 with EN=0 -> irq=0 and CLAIM=0; write EN=0x10 -> irq=1 two cycles later.
REQ-032 rst asserted mid-claim with INSV=0x01 -> all registers, rdata and irq 0 the next cycle; COMPLETE=9 with NSRC=8 ignored.
